// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO-to-stream adapter and its skid store.
package fifo_pkg;

    localparam int FIFO_DATAW = 8;
    localparam int SKID_DEPTH = 3;
    localparam int SKID_PTRW  = 2;

    typedef logic [SKID_PTRW-1:0] skid_ptr_t;

    // Circular pointer advance over the 3-entry store (2 -> 0).
    function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_adapter_skid_store.sv
// 3-entry circular skid store: head/tail pointers, occupancy count, head data mux.
module skid_store
    import fifo_pkg::*;
#(
    parameter int DATAW = FIFO_DATAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [DATAW-1:0] i_push_data,
    input  logic             i_pop,
    output logic [DATAW-1:0] o_head_data,
    output skid_ptr_t        o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [DATAW-1:0] r_mem [SKID_DEPTH];
    skid_ptr_t        r_head;
    skid_ptr_t        r_tail;
    skid_ptr_t        r_count;

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= skid_ptr_inc(r_tail);
            end
            if (i_pop) begin
                r_head <= skid_ptr_inc(r_head);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + skid_ptr_t'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - skid_ptr_t'(1);
            end
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;
    assign o_full      = (r_count == skid_ptr_t'(SKID_DEPTH));
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/fifo_stream_adapter.sv
// FIFO read-port to valid/ready stream adapter with credit-based prefetch.
// Optional beat/stall counters enabled by FIFO_STREAM_ADAPTER_STATS_EN.
module fifo_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATAW = FIFO_DATAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rd_empty,
    input  logic [DATAW-1:0] i_rd_data,
    output logic             o_rd_en,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    input  logic             i_ready
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    output logic [31:0]      o_beat_cnt,
    output logic [31:0]      o_stall_cnt
`endif
);

    logic       r_inflight;
    skid_ptr_t  w_count;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic [2:0] w_credit_used;

    skid_store #(
        .DATAW (DATAW)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (i_rd_data),
        .i_pop       (w_pop),
        .o_head_data (o_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Credit counts both stored beats and the read still in flight, so a
    // capture always has room and i_ready never reaches o_rd_en.
    assign w_credit_used = {1'b0, w_count} + {2'b00, r_inflight};
    assign o_rd_en       = rst_n && !i_rd_empty && !w_full
                           && (w_credit_used < 3'(SKID_DEPTH));
    assign o_valid       = !w_empty;
    assign w_pop         = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_rd_en;
        end
    end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] r_beat_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
            if (o_valid && !i_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_beat_cnt  = r_beat_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
